hd_program_loader: RTL and testbench
====================================

// Module: hd_program_loader
// PURPOSE
//  Upstream feeder of the instruction memory. On a start pulse (issued by the BIOS load-from-HD
//  instruction) it reads WORD_COUNT consecutive 32-bit words from the HD model, beginning at
//  hd_base, and presents each word to the instruction memory with a one-cycle save strobe.
//  It flags completion with the end-of-read code, and flags an error on a bad request or an HD timeout.
// PARAMETERS
//  MEM_DEPTH   201  instruction-memory words (valid write addresses 0..MEM_DEPTH-1)
//  HD_ADDR_W   32   width of HD word address
//  TIMEOUT     16   max cycles waited for hd_valid per word before error
// PORTS
//  clock          in   1   single system clock, all state on posedge
//  reset          in   1   asynchronous, active-low
//  start          in   1   one-cycle load request; ignored unless IDLE
//  hd_base        in   32  first HD word address, sampled with start
//  word_count     in   32  words to transfer, sampled with start
//  mem_base       in   32  first instruction-memory address, sampled with start
//  hd_addr        out  32  HD word address being read
//  hd_rd_en       out  1   HD read request, one cycle per word
//  hd_data        in   32  HD read data
//  hd_valid       in   1   hd_data valid, 1..TIMEOUT cycles after hd_rd_en
//  instr_word     out  32  word presented to instruction memory
//  mem_addr       out  32  write address for instr_word
//  save_ctrl      out  2   2'b01 = write instr_word this cycle, else 2'b00
//  end_ctrl       out  2   2'b00 while loading; 2'b01 after the last word is written
//  busy           out  1   high from the start acceptance through the DONE state
//  done           out  1   one-cycle pulse when the load completes without error
//  error          out  1   sticky until next accepted start; set by bad request or timeout
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE; hd_addr=0, hd_rd_en=0, instr_word=0, mem_addr=0,
//   save_ctrl=00, end_ctrl=00, busy=0, done=0, error=0, internal counters=0.
//   If reset is asserted mid-load, the transfer is aborted; no partial completion is signalled.
//  States: IDLE -> REQ -> WAIT -> WRITE -> (REQ | DONE) -> IDLE; ERR -> IDLE.
//  IDLE: on start, clear error and latch hd_base/mem_base/word_count.
//   Bad request = word_count==0 or mem_base+word_count>MEM_DEPTH (evaluated at full 33-bit width,
//   no wrap). Bad request -> ERR. Otherwise -> REQ with busy=1.
//  REQ (1 cycle): hd_rd_en=1, hd_addr=hd_base+idx; timeout counter cleared -> WAIT.
//  WAIT: when hd_valid=1, capture hd_data into instr_word -> WRITE.
//   hd_valid is honoured on the first WAIT cycle, i.e. one cycle after hd_rd_en.
//   If TIMEOUT cycles pass without hd_valid -> ERR. hd_valid outside WAIT is ignored.
//  WRITE (1 cycle): save_ctrl=01, mem_addr=mem_base+idx, instr_word stable. The instruction
//   memory samples on the following negedge. idx is incremented at the end of this cycle.
//   If idx+1==word_count -> DONE, else -> REQ.
//  DONE (1 cycle): end_ctrl=01, done=1 -> IDLE. end_ctrl then holds 01 in IDLE until the next
//   accepted start; busy=0 once IDLE is reached.
//  ERR (1 cycle): error=1 (sticky), save_ctrl=00, end_ctrl=01 -> IDLE.
//  Throughput: 3 cycles/word at 1-cycle HD latency; the first save_ctrl pulse comes 3 cycles after start.
//  start while busy: ignored, no effect on any output.
//  save_ctrl is never 01 on two consecutive cycles; hd_rd_en never rises while a word is outstanding.
//  idx counts 0..word_count-1 and never wraps. All address sums are 32-bit unsigned.
// TESTING
//  T1 Reset mid-load: deassert-reset, start(hd_base=0x40, count=8), assert reset at word 3 -> all
//     outputs 0 immediately; no further save_ctrl pulses; next start(count=2) completes normally.
//  T2 Basic load: hd_base=0x10, mem_base=0, count=4, HD latency 1 -> 4 save_ctrl pulses, 3 cycles
//     apart, mem_addr 0..3 carrying HD words 0x10..0x13; done pulse; end_ctrl=01.
//  T3 Boundary: mem_base=197, count=4 (total 201) -> accepted, last write to address 200.
//     mem_base=198, count=4 -> error=1, end_ctrl=01, zero save_ctrl pulses.
//  T4 count=0 -> error=1 one cycle after the ERR state; busy never 1; no hd_rd_en.
//  T5 Timeout: HD withholds hd_valid on word 2 -> error=1 after TIMEOUT cycles in WAIT; exactly
//     2 writes issued; done never pulses.
//  T6 start pulsed while busy and variable HD latency (1..15) -> second start ignored; words are
//     written in order with correct addresses; error clears on the next accepted start.

Source files
------------

// File: rtl/hd_program_loader_if.sv
// Bus between the HD program loader, the HD model and the instruction memory.
interface hd_program_loader_if;
  logic        start;
  logic [31:0] hd_base;
  logic [31:0] word_count;
  logic [31:0] mem_base;
  logic [31:0] hd_addr;
  logic        hd_rd_en;
  logic [31:0] hd_data;
  logic        hd_valid;
  logic [31:0] instr_word;
  logic [31:0] mem_addr;
  logic [1:0]  save_ctrl;
  logic [1:0]  end_ctrl;
  logic        busy;
  logic        done;
  logic        error;

  // Loader side
  modport master (
    input  start, hd_base, word_count, mem_base, hd_data, hd_valid,
    output hd_addr, hd_rd_en, instr_word, mem_addr, save_ctrl, end_ctrl,
           busy, done, error
  );

  // Requester / HD / memory side
  modport slave (
    output start, hd_base, word_count, mem_base, hd_data, hd_valid,
    input  hd_addr, hd_rd_en, instr_word, mem_addr, save_ctrl, end_ctrl,
           busy, done, error
  );
endinterface

// File: rtl/hd_program_loader.sv
// Copies word_count words from the HD model into instruction memory,
// one save_ctrl strobe per word, with bad-request and HD-timeout errors.
module hd_program_loader #(
  parameter int unsigned MEM_DEPTH = 201,
  parameter int unsigned HD_ADDR_W = 32,
  parameter int unsigned TIMEOUT   = 16
) (
  input logic              clock,
  input logic              reset,
  hd_program_loader_if.master bus
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t                 state, state_n;
  logic [HD_ADDR_W-1:0]   hd_base_r;
  logic [31:0]            mem_base_r;
  logic [31:0]            cnt_r;
  logic [31:0]            idx;
  logic [TW-1:0]          tcnt;
  logic [31:0]            word_r;
  logic                   end_r;
  logic                   err_r;
  logic [32:0]            req_end;
  logic                   bad_req;

  // Request range check done at 33 bits so mem_base+word_count cannot wrap
  assign req_end = {1'b0, bus.mem_base} + {1'b0, bus.word_count};
  assign bad_req = (bus.word_count == '0) || (req_end > 33'(MEM_DEPTH));

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_n       = state;
    bus.hd_rd_en  = 1'b0;
    bus.save_ctrl = 2'b00;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.end_ctrl  = end_r ? 2'b01 : 2'b00;
    case (state)
      S_IDLE:  if (bus.start) state_n = bad_req ? S_ERR : S_REQ;
      S_REQ: begin
        bus.hd_rd_en = 1'b1;
        bus.busy     = 1'b1;
        state_n      = S_WAIT;
      end
      S_WAIT: begin
        bus.busy = 1'b1;
        if (bus.hd_valid)      state_n = S_WRITE;
        else if (tcnt == TMAX) state_n = S_ERR;
      end
      S_WRITE: begin
        bus.save_ctrl = 2'b01;
        bus.busy      = 1'b1;
        state_n       = (idx + 32'd1 == cnt_r) ? S_DONE : S_REQ;
      end
      S_DONE: begin
        bus.busy     = 1'b1;
        bus.done     = 1'b1;
        bus.end_ctrl = 2'b01;
        state_n      = S_IDLE;
      end
      S_ERR: begin
        bus.end_ctrl = 2'b01;
        state_n      = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Request latching, word counter, timeout counter and sticky flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hd_base_r  <= '0;
      mem_base_r <= '0;
      cnt_r      <= '0;
      idx        <= '0;
      tcnt       <= '0;
      word_r     <= '0;
      end_r      <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          hd_base_r  <= HD_ADDR_W'(bus.hd_base);
          mem_base_r <= bus.mem_base;
          cnt_r      <= bus.word_count;
          idx        <= '0;
          end_r      <= 1'b0;
          err_r      <= 1'b0;
        end
        S_REQ:   tcnt <= '0;
        S_WAIT:  if (bus.hd_valid) word_r <= bus.hd_data;
                 else              tcnt   <= tcnt + 1'b1;
        S_WRITE: idx <= idx + 32'd1;
        S_DONE:  end_r <= 1'b1;
        S_ERR: begin
          end_r <= 1'b1;
          err_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Addresses are sums off the latched bases; meaningful in REQ / WRITE
  assign bus.hd_addr    = 32'(hd_base_r + HD_ADDR_W'(idx));
  assign bus.mem_addr   = mem_base_r + idx;
  assign bus.instr_word = word_r;
  assign bus.error      = err_r;

endmodule

// File: tb/tb_hd_program_loader.sv
// Directed bench for hd_program_loader: a per-cycle timeline model built from
// the load rules, checked every cycle, plus literal pins.
module tb_hd_program_loader;

  localparam int N  = 1024;
  localparam int TO = 16;

  logic clock;
  logic reset;
  int   cyc = 0;

  hd_program_loader_if bus ();

  hd_program_loader #(.MEM_DEPTH(201), .HD_ADDR_W(32), .TIMEOUT(TO)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Expected timeline, indexed by cycle number
  bit          e_rd [N];
  bit          e_save [N];
  bit          e_done [N];
  bit          e_busy [N];
  bit          e_err [N];
  bit          e_end [N];
  bit          e_idle [N];
  logic [31:0] e_hda [N];
  logic [31:0] e_ma [N];
  logic [31:0] e_w [N];

  int          lat_cfg [16];
  logic [31:0] cur_hb = '0;
  int          n_chk = 0;
  int          n_err = 0;

  int p_t1r = -1, p_t1b = -1, p_t2 = -1, p_t3a = -1, p_t3b = -1;
  int p_t4 = -1, p_t5 = -1, p_t6 = -1;

  function automatic logic [31:0] hd_word(logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic void hold_from(int j, bit err, bit endc, bit idle);
    for (int k = j; k < N; k++) begin
      e_err[k]  = err;
      e_end[k]  = endc;
      e_idle[k] = idle;
    end
  endfunction

  function automatic void clear_from(int j);
    for (int k = j; k < N; k++) begin
      e_rd[k] = 0; e_save[k] = 0; e_done[k] = 0; e_busy[k] = 0;
      e_hda[k] = '0; e_ma[k] = '0; e_w[k] = '0;
    end
  endfunction

  // Start seen in cycle c: schedule every word from the per-word HD latencies
  function automatic bit plan(int c, logic [31:0] hb, logic [31:0] mb, logic [31:0] wc);
    int t;
    int lat;
    if (!e_idle[c]) return 0;
    clear_from(c + 1);
    if (wc == 0 || ({1'b0, mb} + {1'b0, wc}) > 33'd201) begin
      hold_from(c + 1, 0, 1, 0);
      hold_from(c + 2, 1, 1, 1);
      return 1;
    end
    hold_from(c + 1, 0, 0, 0);
    t = c + 1;
    for (int i = 0; i < int'(wc); i++) begin
      e_rd[t]   = 1;
      e_hda[t]  = hb + i;
      e_busy[t] = 1;
      lat = lat_cfg[i];
      if (lat == 0) begin
        for (int k = 1; k <= TO; k++) e_busy[t + k] = 1;
        hold_from(t + TO + 1, 0, 1, 0);
        hold_from(t + TO + 2, 1, 1, 1);
        return 1;
      end
      for (int k = 1; k <= lat + 1; k++) e_busy[t + k] = 1;
      e_save[t + lat + 1] = 1;
      e_ma[t + lat + 1]   = mb + i;
      e_w[t + lat + 1]    = hd_word(hb + i);
      t = t + lat + 2;
    end
    e_done[t] = 1;
    e_busy[t] = 1;
    hold_from(t, 0, 1, 0);
    hold_from(t + 1, 0, 1, 1);
    return 1;
  endfunction

  function automatic void model_reset(int k);
    clear_from(k);
    hold_from(k, 0, 0, 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // HD model: answers each read after the configured latency (0 = never)
  bit          pend = 0;
  int          pend_at = 0;
  int          r_li = 0;
  int          r_lat = 0;
  logic [31:0] pend_data = '0;

  always begin
    @(negedge clock);
    if (!reset) pend = 0;
    else if (bus.hd_rd_en && !pend) begin
      r_li  = int'(bus.hd_addr - cur_hb);
      r_lat = (r_li >= 0 && r_li < 16) ? lat_cfg[r_li] : 1;
      if (r_lat != 0) begin
        pend      = 1;
        pend_at   = cyc + r_lat;
        pend_data = hd_word(bus.hd_addr);
      end
    end
    @(posedge clock);
    #1;
    if (pend && cyc == pend_at) begin
      bus.hd_valid = 1'b1;
      bus.hd_data  = pend_data;
      pend         = 0;
    end else begin
      bus.hd_valid = 1'b0;
      bus.hd_data  = 32'hDEAD_BEEF;
    end
  end

  // Compare process: timeline model every cycle, plus literal pins
  always @(negedge clock) begin
    if (cyc < N) begin
      chk("hd_rd_en", 32'(bus.hd_rd_en), e_rd[cyc] ? 32'd1 : 32'd0);
      if (e_rd[cyc]) chk("hd_addr", bus.hd_addr, e_hda[cyc]);
      chk("save_ctrl", 32'(bus.save_ctrl), e_save[cyc] ? 32'd1 : 32'd0);
      if (e_save[cyc]) begin
        chk("mem_addr", bus.mem_addr, e_ma[cyc]);
        chk("instr_word", bus.instr_word, e_w[cyc]);
      end
      chk("done", 32'(bus.done), e_done[cyc] ? 32'd1 : 32'd0);
      chk("busy", 32'(bus.busy), e_busy[cyc] ? 32'd1 : 32'd0);
      chk("error", 32'(bus.error), e_err[cyc] ? 32'd1 : 32'd0);
      chk("end_ctrl", 32'(bus.end_ctrl), e_end[cyc] ? 32'd1 : 32'd0);
      if (!reset) begin
        chk("rst_hd_addr", bus.hd_addr, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_instr_word", bus.instr_word, 32'd0);
      end
      if (p_t1r >= 0 && cyc == p_t1r) begin
        chk("t1_rd_abort", 32'(bus.hd_rd_en), 32'd0);
        chk("t1_busy_abort", 32'(bus.busy), 32'd0);
      end
      if (p_t1b >= 0 && cyc == p_t1b + 7) chk("t1_done_after", 32'(bus.done), 32'd1);
      if (p_t2 >= 0 && cyc == p_t2 + 1) chk("t2_hd_addr0", bus.hd_addr, 32'h10);
      if (p_t2 >= 0 && cyc == p_t2 + 3) begin
        chk("t2_save0", 32'(bus.save_ctrl), 32'd1);
        chk("t2_word0", bus.instr_word, 32'hA5A5_0010);
      end
      if (p_t2 >= 0 && cyc == p_t2 + 12) begin
        chk("t2_maddr3", bus.mem_addr, 32'd3);
        chk("t2_word3", bus.instr_word, 32'hA5A5_0013);
      end
      if (p_t2 >= 0 && cyc == p_t2 + 13) chk("t2_done", 32'(bus.done), 32'd1);
      if (p_t2 >= 0 && cyc == p_t2 + 14) chk("t2_end_hold", 32'(bus.end_ctrl), 32'd1);
      if (p_t3a >= 0 && cyc == p_t3a + 12) chk("t3_last_addr", bus.mem_addr, 32'd200);
      if (p_t3b >= 0 && cyc == p_t3b + 2) chk("t3_bad_error", 32'(bus.error), 32'd1);
      if (p_t4 >= 0 && cyc == p_t4 + 2) chk("t4_error", 32'(bus.error), 32'd1);
      if (p_t5 >= 0 && cyc == p_t5 + 24) chk("t5_err_pre", 32'(bus.error), 32'd0);
      if (p_t5 >= 0 && cyc == p_t5 + 25) chk("t5_err_post", 32'(bus.error), 32'd1);
      if (p_t6 >= 0 && cyc == p_t6 + 1) chk("t6_err_clear", 32'(bus.error), 32'd0);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_load(input logic [31:0] hb, input logic [31:0] mb, input logic [31:0] wc);
    bit acc;
    bus.start      = 1'b1;
    bus.hd_base    = hb;
    bus.mem_base   = mb;
    bus.word_count = wc;
    acc = plan(cyc, hb, mb, wc);
    if (acc) cur_hb = hb;
    step();
    bus.start = 1'b0;
  endtask

  task automatic set_lat(input int a0, input int a1, input int a2, input int a3, input int a4);
    for (int i = 0; i < 16; i++) lat_cfg[i] = 1;
    lat_cfg[0] = a0; lat_cfg[1] = a1; lat_cfg[2] = a2; lat_cfg[3] = a3; lat_cfg[4] = a4;
  endtask

  initial begin
    clock          = 1'b0;
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.hd_base    = '0;
    bus.word_count = '0;
    bus.mem_base   = '0;
    hold_from(0, 0, 0, 1);
    set_lat(1, 1, 1, 1, 1);
    #1 reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    repeat (2) step();

    // T1: reset during word 3 of an 8-word load, then a normal 2-word load
    start_load(32'h40, 32'd10, 32'd8);
    repeat (9) step();
    reset = 1'b0;
    model_reset(cyc);
    p_t1r = cyc;
    repeat (3) step();
    reset = 1'b1;
    step();
    p_t1b = cyc;
    start_load(32'h80, 32'd0, 32'd2);
    repeat (10) step();

    // T2: basic 4-word load at 1-cycle latency
    p_t2 = cyc;
    start_load(32'h10, 32'd0, 32'd4);
    repeat (16) step();

    // T3: range ends exactly at the last address, then one past it
    p_t3a = cyc;
    start_load(32'h100, 32'd197, 32'd4);
    repeat (16) step();
    p_t3b = cyc;
    start_load(32'h300, 32'd198, 32'd4);
    repeat (4) step();

    // T4: zero-length request
    p_t4 = cyc;
    start_load(32'h400, 32'd0, 32'd0);
    repeat (4) step();

    // T5: HD never answers word 2
    set_lat(1, 1, 0, 1, 1);
    p_t5 = cyc;
    start_load(32'h500, 32'd20, 32'd4);
    repeat (30) step();

    // T6: variable latency and a start while busy
    set_lat(3, 1, 15, 7, 2);
    p_t6 = cyc;
    start_load(32'h600, 32'd50, 32'd5);
    repeat (3) step();
    start_load(32'h999, 32'd0, 32'd0);
    repeat (45) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
